connect_suite_rr_arbiter: RTL and testbench
===========================================

CONNECT_SUITE_RR_ARBITER -- requirements
Module: connect_suite_rr_arbiter

Interface
REQ-001 SHALL have parameter N, default 4, meaning the number of requesters (2..16).
REQ-002 SHALL have parameter W, default 8, meaning the payload width in bits.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port io_in_valid, input, N bits: per-requester valid.
REQ-006 SHALL have port io_in_ready, output, N bits: per-requester ready (grant).
REQ-007 SHALL have port io_in_bits, input, N*W bits: payload; requester i occupies bits [i*W+W-1 : i*W].
REQ-008 SHALL have port io_out_valid, output, 1 bit: the output register holds data.
REQ-009 SHALL have port io_out_ready, input, 1 bit: the consumer accepts this cycle.
REQ-010 SHALL have port io_out_bits, output, W bits: registered payload.
REQ-011 SHALL have port io_out_chosen, output, clog2(N) bits: index of the requester that supplied io_out_bits.

Function
REQ-012 SHALL transfer on an input when io_in_valid[i] & io_in_ready[i], and on the output when io_out_valid & io_out_ready.
REQ-013 SHALL compute can_accept = !io_out_valid | io_out_ready, so that back-to-back throughput is one transfer per cycle.
REQ-014 SHALL assert at most one io_in_ready bit per cycle; io_in_ready[i] = can_accept & (i == winner) & io_in_valid[i].
REQ-015 SHALL select the winner round-robin: the first valid requester scanning upward from (last+1) mod N, wrapping past N-1 to 0.
REQ-016 SHALL update last to the winner only on an input transfer; when no transfer occurs, last SHALL hold.
REQ-017 SHALL load io_out_bits/io_out_chosen from the winner on an input transfer and set io_out_valid; latency from input transfer to io_out_valid is 1 cycle.
REQ-018 SHALL clear io_out_valid on an output transfer with no simultaneous input transfer; on a simultaneous transfer, the new data SHALL replace the old with io_out_valid staying 1.
REQ-019 SHALL hold io_out_bits, io_out_chosen and io_out_valid stable while io_out_valid & !io_out_ready (no input accepted).
REQ-020 SHALL have no combinational path from io_in_* to io_out_*; io_out_ready -> io_in_ready is the only combinational path.
REQ-021 SHALL ignore io_in_bits of non-granted requesters; a requester dropping valid before grant is legal and not an error.
REQ-022 SHALL, with a single requester continuously valid and io_out_ready=1, grant it every cycle.

Reset
REQ-023 SHALL, on reset assertion, immediately force io_out_valid=0, io_out_bits=0, io_out_chosen=0 and last=N-1 (requester 0 has first priority), without waiting for clk.
REQ-024 SHALL discard in-flight output data on reset mid-operation; io_in_ready SHALL be all-zero while reset is high.
REQ-025 SHALL resume arbitration on the first rising clk edge after reset deasserts.

Structure
REQ-026 SHALL place no typedefs or constants in a shared package; N and W are local parameters only.
REQ-027 SHALL have a natural sub-module connect_suite_rr_pick (combinational N-bit round-robin priority picker: valid vector plus last index in; winner index and any-valid out); the output register stays in the top.

Verification
REQ-028 SHALL cover: reset, then all 4 valid with io_out_ready=1 -> grants 0,1,2,3,0 on consecutive cycles, and io_out_chosen follows one cycle later.
REQ-029 SHALL cover: only requester 2 valid with bits 0xA5, io_out_ready=1 -> io_out_bits=0xA5 and io_out_chosen=2 one cycle later; granted every cycle.
REQ-030 SHALL cover: io_out_ready=0 for 5 cycles with requesters 1,3 valid -> one load, then io_in_ready=0 and output stable; on release, grant goes to 3 after 1.
REQ-031 SHALL cover: io_out_valid=1 and io_out_ready=1 with requester 0 valid -> simultaneous drain and load; io_out_valid stays 1 with new data.
REQ-032 SHALL cover: reset asserted mid-stream between clk edges -> io_out_valid=0 immediately; the first grant after release goes to the lowest-index valid requester.
REQ-033 SHALL cover: random valid/ready for 10k cycles with a scoreboard -> no loss or duplication, and no requester waits more than N grants.

Source files
------------

// File: rtl/connect_suite_rr_pick.sv
// connect_suite_rr_pick: combinational round-robin picker, first valid requester after last
module connect_suite_rr_pick #(
   parameter int N = 4
) (
   input  logic [N-1:0]         valid_i,
   input  logic [$clog2(N)-1:0] last_i,
   output logic [$clog2(N)-1:0] winner_o,
   output logic                 any_o
);
   localparam int IW = $clog2(N);
   logic [IW-1:0] idx;
   // scan offsets from farthest to nearest so the nearest valid requester after last wins
   always_comb begin
      winner_o = '0;
      any_o    = 1'b0;
      idx      = '0;
      for (int k = N; k >= 1; k--) begin
         idx = IW'((int'(last_i) + k) % N);
         if (valid_i[idx]) begin
            winner_o = idx;
            any_o    = 1'b1;
         end
      end
   end
endmodule

// File: rtl/connect_suite_rr_arbiter.sv
// connect_suite_rr_arbiter: N-way round-robin arbiter feeding a single registered output slot
module connect_suite_rr_arbiter #(
   parameter int N = 4,
   parameter int W = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic [N-1:0]         io_in_valid,
   output logic [N-1:0]         io_in_ready,
   input  logic [N*W-1:0]       io_in_bits,
   output logic                 io_out_valid,
   input  logic                 io_out_ready,
   output logic [W-1:0]         io_out_bits,
   output logic [$clog2(N)-1:0] io_out_chosen
);
   localparam int IW = $clog2(N);
   logic [IW-1:0] last_q, last_d, chosen_q, chosen_d, winner;
   logic [W-1:0]  bits_q, bits_d, win_bits;
   logic [N-1:0]  grant;
   logic          valid_q, valid_d, any_valid, can_accept, in_fire;
   connect_suite_rr_pick #(.N(N)) u_pick (
      .valid_i  (io_in_valid),
      .last_i   (last_q),
      .winner_o (winner),
      .any_o    (any_valid)
   );
   // one-hot of the winner and its payload slice; other requesters' bits are never looked at
   always_comb begin
      grant    = '0;
      win_bits = '0;
      for (int i = 0; i < N; i++) begin
         if (winner == IW'(i)) begin
            grant[i] = 1'b1;
            win_bits = io_in_bits[i*W +: W];
         end
      end
   end
   assign can_accept  = !valid_q | io_out_ready;
   assign io_in_ready = (can_accept && any_valid && !reset) ? (grant & io_in_valid) : '0;
   assign in_fire     = |io_in_ready;
   // next state: load on input transfer, drain on output transfer, otherwise hold
   always_comb begin
      last_d   = in_fire ? winner : last_q;
      valid_d  = in_fire | (valid_q & !io_out_ready);
      bits_d   = in_fire ? win_bits : bits_q;
      chosen_d = in_fire ? winner : chosen_q;
   end
   // output slot and round-robin pointer; reset gives requester 0 first priority
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         last_q   <= IW'(N - 1);
         valid_q  <= 1'b0;
         bits_q   <= '0;
         chosen_q <= '0;
      end else begin
         last_q   <= last_d;
         valid_q  <= valid_d;
         bits_q   <= bits_d;
         chosen_q <= chosen_d;
      end
   end
   assign io_out_valid  = valid_q;
   assign io_out_bits   = bits_q;
   assign io_out_chosen = chosen_q;
endmodule

// File: tb/tb_connect_suite_rr_arbiter.sv
// tb_connect_suite_rr_arbiter: vector table, directed corner sequences and random run against a reference model
module tb_connect_suite_rr_arbiter;
   localparam int N = 4;
   localparam int W = 8;
   logic           clk = 1'b0;
   logic           reset;
   logic [N-1:0]   io_in_valid, io_in_ready;
   logic [N*W-1:0] io_in_bits;
   logic           io_out_valid, io_out_ready;
   logic [W-1:0]   io_out_bits;
   logic [1:0]     io_out_chosen;

   connect_suite_rr_arbiter #(.N(N), .W(W)) dut (
      .clk           (clk),
      .reset         (reset),
      .io_in_valid   (io_in_valid),
      .io_in_ready   (io_in_ready),
      .io_in_bits    (io_in_bits),
      .io_out_valid  (io_out_valid),
      .io_out_ready  (io_out_ready),
      .io_out_bits   (io_out_bits),
      .io_out_chosen (io_out_chosen)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [N-1:0]   v;
      logic [N*W-1:0] b;
      logic           r;
      logic [N-1:0]   er;
      logic           ov;
      logic [W-1:0]   ob;
      logic [1:0]     oc;
   } vec_t;

   typedef struct {
      int         idx;
      logic [7:0] d;
   } item_t;

   int checks = 0;
   int passed = 0;
   int m_last, m_oc;
   bit m_ov;
   logic [W-1:0] m_ob;
   item_t sb[$];
   int wt[N];
   int max_wait = 0;
   logic [N-1:0] g_last;

   task automatic chk(string name, longint act, longint exp);
      checks++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   function automatic int pick(logic [N-1:0] v, int last);
      for (int k = 1; k <= N; k++) if (v[(last + k) % N]) return (last + k) % N;
      return -1;
   endfunction

   task automatic model_reset();
      m_last = N - 1;
      m_ov = 1'b0;
      m_ob = '0;
      m_oc = 0;
      sb.delete();
      for (int i = 0; i < N; i++) wt[i] = 0;
   endtask

   // called at a falling edge: drive, check against the model, advance the model, go to next falling edge
   task automatic step(logic [N-1:0] v, logic [N*W-1:0] b, logic r);
      int w;
      logic [N-1:0] er, g;
      item_t it;
      io_in_valid = v;
      io_in_bits = b;
      io_out_ready = r;
      #1;
      w = pick(v, m_last);
      er = ((!m_ov || r) && w >= 0) ? 4'(1 << w) : '0;
      chk("in_ready", io_in_ready, er);
      chk("out_valid", io_out_valid, m_ov);
      chk("out_bits", io_out_bits, m_ob);
      chk("out_chosen", io_out_chosen, m_oc);
      g = io_in_ready & v;
      g_last = g;
      if (io_out_valid && r) begin
         chk("sb_depth", sb.size(), 1);
         if (sb.size() != 0) begin
            it = sb.pop_front();
            chk("sb_bits", io_out_bits, it.d);
            chk("sb_chosen", io_out_chosen, it.idx);
         end
      end
      for (int i = 0; i < N; i++) begin
         if (g[i]) begin
            it.idx = i;
            it.d = b[i*W +: W];
            sb.push_back(it);
         end
      end
      for (int i = 0; i < N; i++) begin
         if (!v[i] || g[i]) wt[i] = 0;
         else if (|g) begin
            wt[i]++;
            if (wt[i] > max_wait) max_wait = wt[i];
         end
      end
      if (w >= 0 && (!m_ov || r)) begin
         m_last = w;
         m_ov = 1'b1;
         m_ob = b[w*W +: W];
         m_oc = w;
      end else if (r) m_ov = 1'b0;
      @(negedge clk);
   endtask

   // asserts reset between clock edges and checks the outputs clear without a clock edge
   task automatic do_reset();
      #2 reset = 1'b1;
      #1;
      chk("rst_out_valid", io_out_valid, 0);
      chk("rst_out_bits", io_out_bits, 0);
      chk("rst_out_chosen", io_out_chosen, 0);
      chk("rst_in_ready", io_in_ready, 0);
      model_reset();
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      vec_t tab[9];
      logic [N-1:0] vr;
      tab[0] = '{4'hF, 32'h44332211, 1'b1, 4'h1, 1'b0, 8'h00, 2'd0};
      tab[1] = '{4'hF, 32'h44332211, 1'b1, 4'h2, 1'b1, 8'h11, 2'd0};
      tab[2] = '{4'hF, 32'h44332211, 1'b1, 4'h4, 1'b1, 8'h22, 2'd1};
      tab[3] = '{4'hF, 32'h44332211, 1'b1, 4'h8, 1'b1, 8'h33, 2'd2};
      tab[4] = '{4'hF, 32'h44332211, 1'b1, 4'h1, 1'b1, 8'h44, 2'd3};
      tab[5] = '{4'hF, 32'h44332211, 1'b1, 4'h2, 1'b1, 8'h11, 2'd0};
      tab[6] = '{4'h4, 32'h00A50000, 1'b1, 4'h4, 1'b1, 8'h22, 2'd1};
      tab[7] = '{4'h4, 32'h00A50000, 1'b1, 4'h4, 1'b1, 8'hA5, 2'd2};
      tab[8] = '{4'h4, 32'h00A50000, 1'b1, 4'h4, 1'b1, 8'hA5, 2'd2};
      reset = 1'b1;
      io_in_valid = '0;
      io_in_bits = '0;
      io_out_ready = 1'b0;
      g_last = '0;
      model_reset();
      @(negedge clk);
      @(negedge clk);
      chk("init_out_valid", io_out_valid, 0);
      chk("init_in_ready", io_in_ready, 0);
      reset = 1'b0;
      for (int t = 0; t < 9; t++) begin
         io_in_valid = tab[t].v;
         io_in_bits = tab[t].b;
         io_out_ready = tab[t].r;
         #1;
         chk($sformatf("tab%0d_in_ready", t), io_in_ready, tab[t].er);
         chk($sformatf("tab%0d_out_valid", t), io_out_valid, tab[t].ov);
         chk($sformatf("tab%0d_out_bits", t), io_out_bits, tab[t].ob);
         chk($sformatf("tab%0d_out_chosen", t), io_out_chosen, tab[t].oc);
         @(negedge clk);
      end
      do_reset();
      step(4'b1010, 32'h5A003C00, 1'b0);
      for (int i = 0; i < 5; i++) begin
         step(4'b1010, 32'h5A003C00, 1'b0);
         chk("stall_bits", io_out_bits, 8'h3C);
         chk("stall_chosen", io_out_chosen, 1);
      end
      step(4'b1010, 32'h5A003C00, 1'b1);
      chk("release_chosen", io_out_chosen, 3);
      chk("release_bits", io_out_bits, 8'h5A);
      step(4'b0001, 32'h00000077, 1'b1);
      chk("swap_valid", io_out_valid, 1);
      chk("swap_bits", io_out_bits, 8'h77);
      chk("swap_chosen", io_out_chosen, 0);
      for (int i = 0; i < 3; i++) step(4'hF, 32'h0D0C0B0A, 1'b1);
      do_reset();
      step(4'b1100, 32'hBBAA0000, 1'b1);
      chk("post_rst_chosen", io_out_chosen, 2);
      chk("post_rst_bits", io_out_bits, 8'hAA);
      vr = '0;
      for (int c = 0; c < 10000; c++) begin
         vr = (vr & ~g_last) | 4'($urandom);
         if ($urandom_range(0, 15) == 0) vr = vr & 4'($urandom);
         step(vr, $urandom, $urandom_range(0, 3) != 0);
      end
      chk("max_wait_le_N", max_wait <= N, 1);
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end
endmodule
